mod_mult: RTL and testbench

Bit-serial interleaved modular multiplier computing result = (A × B) mod M for WIDTH-bit operands, one multiplier bit per clock. It is the multiply engine that `mod_power` drives for each square and multiply step of RSA exponentiation. It uses a start/busy/done handshake so `mod_power` can sequence repeated multiplications without tracking internal timing.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/mod_mult_if.sv | 25 ++
 rtl/mod_mult_step.sv | 29 ++
 rtl/mod_mult.sv | 109 ++++++++++
 tb/tb_mod_mult.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA arithmetic blocks: default operand width,
// multiplier FSM states and the accumulator width rule.
package rsa_pkg;

    localparam int WIDTH_DEFAULT = 512;

    // The accumulator holds 2P + A < 4M, so it needs two bits above the operands.
    function automatic int acc_width(input int w);
        return w + 2;
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : rsa_pkg

// File: rtl/mod_mult_if.sv
// Start/busy/done handshake and operand/result buses of the modular multiplier.
interface mod_mult_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] M;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, A, B, M,
        input  busy, done, result
    );

    modport slave (
        input  start, A, B, M,
        output busy, done, result
    );

endinterface : mod_mult_if

// File: rtl/mod_mult_step.sv
// One interleaved multiply iteration: P <- 2P (+A if b), then reduce below M
// with up to two conditional subtractions.
module mod_mult_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH+1:0] p_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             b_i,
    output logic [WIDTH+1:0] p_o
);

    logic [WIDTH+1:0] dbl;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sub1;

    always_comb begin
        // P < M on entry, so the top accumulator bit is always zero before the shift.
        dbl   = {p_i[WIDTH:0], 1'b0};
        m_ext = {2'b00, m_i};
        sum   = dbl + (b_i ? {2'b00, a_i} : '0);
        sub1  = (sum >= m_ext) ? (sum - m_ext) : sum;
        p_o   = (sub1 >= m_ext) ? (sub1 - m_ext) : sub1;
    end

endmodule : mod_mult_step

// File: rtl/mod_mult.sv
// Bit-serial interleaved modular multiplier: result = (A * B) mod M,
// scanning B from MSB to LSB, one bit per clock.
module mod_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic       aclk,
    input  logic       aresetn,
    mod_mult_if.slave  bus
);

    localparam int ACC_W = acc_width(WIDTH);
    localparam int IDX_W = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [ACC_W-1:0]  p_q, p_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  p_step;

    mod_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i (p_q),
        .a_i (a_q),
        .m_i (m_q),
        .b_i (b_q[idx_q]),
        .p_o (p_step)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        p_d      = p_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    m_d     = bus.M;
                    p_d     = '0;
                    idx_d   = IDX_W'(WIDTH - 1);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                p_d   = p_step;
                idx_d = idx_q - IDX_W'(1);
                // Result is captured with the last step so it appears alongside done.
                if (idx_q == '0) begin
                    state_d  = DONE;
                    idx_d    = '0;
                    result_d = p_step[WIDTH-1:0];
                    done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule : mod_mult

// File: tb/tb_mod_mult.sv
// Directed test of mod_mult at WIDTH=8 and WIDTH=512 with hand-computed results.
module tb_mod_mult;
    import rsa_pkg::*;

    logic aclk;
    logic aresetn;

    int n_cmp = 0;
    int n_err = 0;

    mod_mult_if #(.WIDTH(8))   bus8 ();
    mod_mult_if #(.WIDTH(512)) bus512 ();

    mod_mult #(.WIDTH(8)) u_dut8 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus8)
    );

    mod_mult #(.WIDTH(512)) u_dut512 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus512)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        bus8.A     = a;
        bus8.B     = b;
        bus8.M     = m;
        bus8.start = 1'b1;
        @(negedge aclk);
        bus8.start = 1'b0;
    endtask

    // Counts negedges until done, and how many of them saw busy high.
    task automatic wait_done8(input int max_cyc, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!bus8.done && cyc < max_cyc) begin
            @(negedge aclk);
            cyc++;
            if (bus8.busy) busy_cnt++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;
        int pulses;
        int t_done [3];
        logic [7:0] res_seen;
        logic [511:0] m_big;
        logic [511:0] a_big;
        logic [511:0] exp_big;

        aresetn      = 1'b0;
        bus8.start   = 1'b0;
        bus8.A       = '0;
        bus8.B       = '0;
        bus8.M       = '0;
        bus512.start = 1'b0;
        bus512.A     = '0;
        bus512.B     = '0;
        bus512.M     = '0;
        repeat (2) @(negedge aclk);
        check("rst_busy8", 512'(bus8.busy), 512'd0);
        check("rst_done8", 512'(bus8.done), 512'd0);
        check("rst_result8", 512'(bus8.result), 512'd0);
        check("rst_busy512", 512'(bus512.busy), 512'd0);
        check("rst_result512", bus512.result, 512'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // 5*7 = 35 mod 11 = 2
        start8(8'd5, 8'd7, 8'd11);
        check("t1_busy_rise", 512'(bus8.busy), 512'd1);
        wait_done8(20, cyc, bcnt);
        check("t1_latency", 512'(cyc), 512'd8);
        check("t1_busy_cycles", 512'(bcnt + 1), 512'd9);
        check("t1_result", 512'(bus8.result), 512'd2);
        $display("op 8-bit 5*7 mod 11 -> %0d after %0d cycles", bus8.result, cyc + 1);
        @(negedge aclk);
        check("t1_done_pulse", 512'(bus8.done), 512'd0);
        check("t1_busy_drop", 512'(bus8.busy), 512'd0);
        check("t1_result_hold", 512'(bus8.result), 512'd2);

        // 250*250 = 62500 = 249*251 + 1
        start8(8'd250, 8'd250, 8'd251);
        wait_done8(20, cyc, bcnt);
        check("t2_result", 512'(bus8.result), 512'd1);
        $display("op 8-bit 250*250 mod 251 -> %0d", bus8.result);
        @(negedge aclk);
        start8(8'd0, 8'd200, 8'd251);
        wait_done8(20, cyc, bcnt);
        check("t2_zero", 512'(bus8.result), 512'd0);
        $display("op 8-bit 0*200 mod 251 -> %0d", bus8.result);
        @(negedge aclk);
        start8(8'd7, 8'd3, 8'd5);
        wait_done8(20, cyc, bcnt);
        check("t2_nonzero", 512'(bus8.result), 512'd1);
        $display("op 8-bit 7*3 mod 5 -> %0d", bus8.result);
        @(negedge aclk);
        start8(8'd0, 8'd0, 8'd1);
        wait_done8(20, cyc, bcnt);
        check("t2_m1", 512'(bus8.result), 512'd0);
        $display("op 8-bit 0*0 mod 1 -> %0d", bus8.result);
        @(negedge aclk);

        // M = 0 violates the precondition; only the handshake timing is defined.
        start8(8'd5, 8'd7, 8'd0);
        wait_done8(20, cyc, bcnt);
        check("t2_m0_latency", 512'(cyc), 512'd8);
        $display("op 8-bit M=0 done after %0d cycles", cyc + 1);
        @(negedge aclk);

        // 512-bit: 10*10 = 100 mod 11 = 1
        bus512.A = 512'd10;
        bus512.B = 512'd10;
        bus512.M = 512'd11;
        bus512.start = 1'b1;
        @(negedge aclk);
        bus512.start = 1'b0;
        cyc = 0;
        while (!bus512.done && cyc < 600) begin
            @(negedge aclk);
            cyc++;
        end
        check("t3_latency", 512'(cyc), 512'd512);
        check("t3_result", bus512.result, 512'd1);
        $display("op 512-bit 10*10 mod 11 -> %0d after %0d cycles", bus512.result, cyc + 1);
        @(negedge aclk);

        // (M-1)*2 mod M with M = 2^511+1 gives M-2 = 2^511-1
        m_big   = (512'd1 << 511) + 512'd1;
        a_big   = m_big - 512'd1;
        exp_big = (512'd1 << 511) - 512'd1;
        bus512.A = a_big;
        bus512.B = 512'd2;
        bus512.M = m_big;
        bus512.start = 1'b1;
        @(negedge aclk);
        bus512.start = 1'b0;
        cyc = 0;
        while (!bus512.done && cyc < 600) begin
            @(negedge aclk);
            cyc++;
        end
        check("t3_big_result", bus512.result, exp_big);
        $display("op 512-bit (M-1)*2 mod (2^511+1) -> msb %0b lsb %0b", bus512.result[511], bus512.result[0]);
        @(negedge aclk);

        // Start pulse during RUN with new operands must be ignored.
        start8(8'd5, 8'd7, 8'd11);
        repeat (2) @(negedge aclk);
        bus8.A = 8'd3;
        bus8.B = 8'd4;
        bus8.M = 8'd13;
        bus8.start = 1'b1;
        @(negedge aclk);
        bus8.start = 1'b0;
        pulses = 0;
        res_seen = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge aclk);
            if (bus8.done) begin
                pulses++;
                res_seen = bus8.result;
            end
        end
        check("t4_pulses", 512'(pulses), 512'd1);
        check("t4_result", 512'(res_seen), 512'd2);
        $display("op 8-bit busy-start ignored: %0d done pulse(s), result %0d", pulses, res_seen);

        // Reset in the middle of RUN discards the computation.
        start8(8'd5, 8'd7, 8'd11);
        repeat (3) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        check("t5_busy", 512'(bus8.busy), 512'd0);
        check("t5_done", 512'(bus8.done), 512'd0);
        check("t5_result", 512'(bus8.result), 512'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            if (bus8.done) pulses++;
        end
        check("t5_no_done", 512'(pulses), 512'd0);
        start8(8'd6, 8'd6, 8'd7);
        wait_done8(20, cyc, bcnt);
        check("t5_restart", 512'(bus8.result), 512'd1);
        $display("op 8-bit after mid-run reset 6*6 mod 7 -> %0d", bus8.result);
        @(negedge aclk);

        // Start held high: one operation every WIDTH+2 cycles.
        bus8.A = 8'd3;
        bus8.B = 8'd3;
        bus8.M = 8'd5;
        bus8.start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40 && pulses < 3; k++) begin
            @(negedge aclk);
            if (bus8.done) begin
                t_done[pulses] = k;
                pulses++;
                check("t6_result", 512'(bus8.result), 512'd4);
                $display("op 8-bit held start 3*3 mod 5 -> %0d at cycle %0d", bus8.result, k);
            end
        end
        bus8.start = 1'b0;
        check("t6_pulses", 512'(pulses), 512'd3);
        if (pulses == 3) begin
            check("t6_period_a", 512'(t_done[1] - t_done[0]), 512'd10);
            check("t6_period_b", 512'(t_done[2] - t_done[1]), 512'd10);
        end
        repeat (12) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mod_mult
